generador_estimulos: RTL and testbench

//   Synthesizable stimulus source for the pipelined adder bench; it drives the opposite end of the compare path from verificador.

---
 rtl/generador_estimulos.sv | 170 +++++++++++++++++
 tb/tb_generador_estimulos.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/generador_estimulos.sv
// Stimulus source for the pipelined adder bench.
// It plays every operand pair once, then a short run of LFSR pairs, then
// waits for the pipeline to drain. Alongside the operands it produces the
// golden sum, delayed so that it lines up with the DUT outputs.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | after reset, outputs quiet, waiting for start
// S_SWEEP  | exhaustive operand sweep, one pair per cycle
// S_RANDOM | N_RANDOM pseudo-random pairs taken from the LFSR
// S_DRAIN  | PIPE_LAT quiet cycles so the last golden sums come out
// S_DONE   | sequence complete, done held, waiting for start
module generador_estimulos #(
  parameter int          BITS     = 2,
  parameter int          PIPE_LAT = 2,
  parameter int          N_RANDOM = 16,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [BITS-1:0] dato_A,
  output logic [BITS-1:0] dato_B,
  output logic            valid_out,
  output logic [BITS:0]   esperado,
  output logic            valid_esperado,
  output logic            busy,
  output logic            done
);

  localparam int CW = 2 * BITS;
  localparam int RW = (N_RANDOM > 1) ? $clog2(N_RANDOM) : 1;
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int EW = BITS + 2;

  localparam logic [CW-1:0] CNT_LAST  = '1;
  localparam logic [RW-1:0] RND_LOAD  = RW'(N_RANDOM - 1);
  localparam logic [DW-1:0] DRN_LOAD  = DW'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWEEP,
    S_RANDOM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   rnd_q, rnd_d;
  logic [DW-1:0]   drn_q, drn_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [15:0]     lfsr_next;
  logic [BITS-1:0] dato_a_q, dato_a_d;
  logic [BITS-1:0] dato_b_q, dato_b_d;
  logic            valid_q, valid_d;
  logic [BITS:0]   sum;

  // Each delay-line stage holds {sum, valid}; stage 0 is the newest.
  logic [PIPE_LAT-1:0][EW-1:0] dl_q, dl_d;

  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign sum       = {1'b0, dato_a_q} + {1'b0, dato_b_q};

  // Next-state logic; the operand registers are loaded with the pair that
  // the upcoming state shows, so the pair appears in the same cycle as the state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rnd_d    = rnd_q;
    drn_d    = drn_q;
    lfsr_d   = lfsr_q;
    dato_a_d = '0;
    dato_b_d = '0;
    valid_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SWEEP;
          cnt_d   = '0;
          lfsr_d  = SEED;
          valid_d = 1'b1;
        end
      end
      S_SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          if (N_RANDOM > 0) begin
            // lfsr still holds SEED here, so the first random pair comes from it.
            state_d  = S_RANDOM;
            rnd_d    = RND_LOAD;
            dato_a_d = lfsr_q[BITS-1:0];
            dato_b_d = lfsr_q[CW-1:BITS];
            valid_d  = 1'b1;
          end else begin
            state_d = S_DRAIN;
            drn_d   = DRN_LOAD;
          end
        end else begin
          dato_a_d = cnt_d[BITS-1:0];
          dato_b_d = cnt_d[CW-1:BITS];
          valid_d  = 1'b1;
        end
      end
      S_RANDOM: begin
        lfsr_d = lfsr_next;
        if (rnd_q == '0) begin
          state_d = S_DRAIN;
          drn_d   = DRN_LOAD;
        end else begin
          rnd_d    = rnd_q - 1'b1;
          dato_a_d = lfsr_next[BITS-1:0];
          dato_b_d = lfsr_next[CW-1:BITS];
          valid_d  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drn_q == '0) begin
          state_d = S_DONE;
        end else begin
          drn_d = drn_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Golden delay line: shift {sum, valid} one stage per cycle.
  always_comb begin
    dl_d    = dl_q;
    dl_d[0] = {sum, valid_q};
    for (int i = 1; i < PIPE_LAT; i++) begin
      dl_d[i] = dl_q[i-1];
    end
  end

  // State, counters, operands and delay line; reset overrides start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rnd_q    <= '0;
      drn_q    <= '0;
      lfsr_q   <= SEED;
      dato_a_q <= '0;
      dato_b_q <= '0;
      valid_q  <= 1'b0;
      dl_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rnd_q    <= rnd_d;
      drn_q    <= drn_d;
      lfsr_q   <= lfsr_d;
      dato_a_q <= dato_a_d;
      dato_b_q <= dato_b_d;
      valid_q  <= valid_d;
      dl_q     <= dl_d;
    end
  end

  assign dato_A         = dato_a_q;
  assign dato_B         = dato_b_q;
  assign valid_out      = valid_q;
  assign esperado       = dl_q[PIPE_LAT-1][EW-1:1];
  assign valid_esperado = dl_q[PIPE_LAT-1][0];
  assign busy           = (state_q == S_SWEEP) || (state_q == S_RANDOM) || (state_q == S_DRAIN);
  assign done           = (state_q == S_DONE);

endmodule

// File: tb/tb_generador_estimulos.sv
// Directed bench for generador_estimulos with BITS=2, PIPE_LAT=2, N_RANDOM=4.
// Cycle c of a run is the cycle that follows the edge c-1 edges after the
// edge that sampled start; expected values per cycle sit in a table.
module tb_generador_estimulos;

  localparam int BITS     = 2;
  localparam int PIPE_LAT = 2;
  localparam int N_RANDOM = 4;
  localparam int N_CYC    = 23;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [BITS-1:0] dato_A, dato_B;
  logic            valid_out;
  logic [BITS:0]   esperado;
  logic            valid_esperado;
  logic            busy, done;

  int n_vec = 0;
  int n_err = 0;

  int e_a    [0:N_CYC];
  int e_b    [0:N_CYC];
  int e_v    [0:N_CYC];
  int e_busy [0:N_CYC];
  int e_done [0:N_CYC];
  int e_esp  [0:N_CYC];
  int e_vesp [0:N_CYC];

  generador_estimulos #(
    .BITS(BITS), .PIPE_LAT(PIPE_LAT), .N_RANDOM(N_RANDOM), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .dato_A(dato_A), .dato_B(dato_B), .valid_out(valid_out),
    .esperado(esperado), .valid_esperado(valid_esperado),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " A"},    32'(dato_A), 0);
    chk({tag, " B"},    32'(dato_B), 0);
    chk({tag, " vout"}, 32'(valid_out), 0);
    chk({tag, " esp"},  32'(esperado), 0);
    chk({tag, " vesp"}, 32'(valid_esperado), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
  endtask

  task automatic chk_cycle(input string tag, input int c);
    string t;
    t = $sformatf("%s c%0d", tag, c);
    chk({t, " A"},    32'(dato_A),         32'(e_a[c]));
    chk({t, " B"},    32'(dato_B),         32'(e_b[c]));
    chk({t, " vout"}, 32'(valid_out),      32'(e_v[c]));
    chk({t, " esp"},  32'(esperado),       32'(e_esp[c]));
    chk({t, " vesp"}, 32'(valid_esperado), 32'(e_vesp[c]));
    chk({t, " busy"}, 32'(busy),           32'(e_busy[c]));
    chk({t, " done"}, 32'(done),           32'(e_done[c]));
  endtask

  // Start is driven high in the current cycle; start is also held high
  // during cycles p_lo..p_hi of the run.
  task automatic run_seq(input string tag, input int p_lo, input int p_hi, input int n_cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= n_cyc; c++) begin
      chk_cycle(tag, c);
      if (c < n_cyc) begin
        start = (c >= p_lo) && (c <= p_hi);
        tick();
      end
    end
    start = 1'b0;
  endtask

  // Expected table. Sweep: cycle c shows cnt=c-1, A=cnt[1:0], B=cnt[3:2].
  // Random pairs from SEED 0xACE1 -> 0x59C3 -> 0xB387 -> 0x670F:
  // (1,0) (3,0) (3,1) (3,3).
  initial begin
    for (int c = 0; c <= N_CYC; c++) begin
      e_a[c] = 0; e_b[c] = 0; e_v[c] = 0; e_esp[c] = 0; e_vesp[c] = 0;
      e_busy[c] = (c >= 1 && c <= 22) ? 1 : 0;
      e_done[c] = (c == 23) ? 1 : 0;
    end
    for (int c = 1; c <= 16; c++) begin
      e_a[c] = (c - 1) % 4;
      e_b[c] = (c - 1) / 4;
      e_v[c] = 1;
    end
    e_a[17] = 1; e_b[17] = 0; e_v[17] = 1;
    e_a[18] = 3; e_b[18] = 0; e_v[18] = 1;
    e_a[19] = 3; e_b[19] = 1; e_v[19] = 1;
    e_a[20] = 3; e_b[20] = 3; e_v[20] = 1;
    for (int c = PIPE_LAT + 1; c <= N_CYC; c++) begin
      e_esp[c]  = e_a[c-PIPE_LAT] + e_b[c-PIPE_LAT];
      e_vesp[c] = e_v[c-PIPE_LAT];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet("rst");
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_quiet("idle");
    end

    // Fixed spot checks against the hand-derived numbers.
    chk("tbl A@6",    32'(e_a[6]),    1);
    chk("tbl esp@18", 32'(e_esp[18]), 6);

    run_seq("run1", 0, -1, N_CYC);
    run_seq("restart", 0, -1, N_CYC);
    run_seq("startpulse", 5, 8, N_CYC);

    run_seq("abort", 0, -1, 10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_quiet("abort c11");
    tick();
    run_seq("after_rst", 0, -1, N_CYC);

    // Reset wins over start when both are high in DONE.
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk_quiet("rst_prio");
    tick();
    chk_quiet("rst_prio2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
